fft_frame_rx: RTL
=================

// Module: fft_frame_rx
// PURPOSE
// - Receive end of the FFT output interface: consumes the 16-lane fft_valid bursts (real frame, then imag frame).
// - Pairs each real frame with its imag frame and buffers the pair.
// - Emits one complex bin per cycle on a valid/ready stream, and reports the per-frame peak bin.
// - Sits between the FFT core and downstream spectral logic/storage; mirrors the bench's real/imag alternation in RTL.
// PARAMETERS
// - W      16    sample width, signed Q8.8
// - LANES  16    bins per fft_valid beat
// - NBINS  1024  bins per transform; out_idx wraps modulo NBINS
// - IDXW   10    width of bin index, = log2(NBINS)
// PORTS
// - clk          in   1        rising-edge clock
// - rst          in   1        synchronous, active-low reset (0 = reset)
// - fft_valid    in   1        one beat of 16 lanes present
// - fft_bus      in   W*LANES  lane k at [W*k+W-1:W*k]; k = bin order within frame
// - done         in   1        FFT finished; level or pulse
// - out_valid    out  1        complex bin available
// - out_ready    in   1        downstream accepts when out_valid&&out_ready
// - out_re       out  W        real part
// - out_im       out  W        imag part
// - out_idx      out  IDXW     global bin index of current output
// - out_last     out  1        lane 15 of a frame
// - peak_valid   out  1        1-cycle pulse when a frame's last bin is accepted
// - peak_idx     out  IDXW     global index of max |re|+|im| in that frame
// - peak_mag     out  W+1      that magnitude, unsigned
// - ovf          out  1        sticky: a completed pair was dropped, buffer full
// - orphan       out  1        sticky: done arrived with an unpaired real frame
// - rx_done      out  1        sticky: all received pairs drained after done
// BEHAVIOUR
// - Reset: all outputs 0; pair FSM=WAIT_RE; slots empty; idx counter=0; flags clear.
//   Reset mid-stream discards all buffered data.
// - Pair FSM:
//   - WAIT_RE + fft_valid: latch fft_bus into re_hold, go to WAIT_IM.
//   - WAIT_IM + fft_valid: commit {re_hold, fft_bus} into a free slot, go to WAIT_RE.
//   - Back-to-back beats are legal.
// - Buffer: 2 frame slots in ping-pong order, written and read in arrival order.
//   - A slot freed by the drain in cycle N is usable by a commit in the same cycle N.
//   - Commit with no free slot: the pair is dropped, ovf<=1, FSM still returns to WAIT_RE.
// - Drain FSM: IDLE -> DRAIN when a slot is full.
//   - DRAIN presents lane cnt of the head slot (cnt 0..15); advances only on out_valid&&out_ready.
//   - out_valid rises on the cycle after the commit (latency 1).
//   - out_re/out_im/out_idx are stable while out_valid && !out_ready.
//   - After lane 15 is accepted: slot freed; go to the next slot with no bubble if it is full, else IDLE.
//   - out_idx increments on each accept; NBINS-1 -> 0.
// - Peak:
//   - mag = |re| + |im|; |-32768| saturates to 32767; mag range 0..65534.
//   - Strict > comparison, so the first maximum wins.
//   - peak_* registered; peak_valid is 1 cycle after the last-lane accept.
// - done: latched into done_seen.
//   - If the pair FSM is in WAIT_IM when done is seen: orphan<=1, re_hold discarded, FSM=WAIT_RE.
//   - rx_done<=1 when done_seen && WAIT_RE && both slots empty && drain IDLE.
//   - rx_done stays 1 until reset; later fft_valid is ignored.
// - Sustained rate: 1 pair per 16 cycles (FIR rate) with out_ready=1 never overflows.
// STRUCTURE
// - Package fft_rx_pkg:
//   - W, LANES, NBINS, IDXW
//   - typedef logic signed [W-1:0] sample_t
//   - typedef sample_t frame_t [LANES]
//   - enums pair_st_e {WAIT_RE, WAIT_IM} and drain_st_e {IDLE, DRAIN}
// - Sub-module fft_abs_sum: combinational |re|+|im| with saturation, (W+1)-bit output.
// - Top holds the two FSMs, slot array, head/tail pointers and peak tracker.
// TESTING
// 1. Real beat lanes k=k*16'h0100, then imag beat all 0, out_ready=1
//    -> 16 outputs, out_re=k<<8, out_idx 0..15, out_last on 15; peak_idx=15, peak_mag=16'h0F00.
// 2. Three pairs back-to-back (6 consecutive fft_valid), out_ready=0 for 60 cycles
//    -> ovf=1; third pair lost; after out_ready=1, 32 bins of pairs 1 and 2 only.
// 3. out_ready toggled 1010... during drain
//    -> outputs held stable while stalled; no bin duplicated or skipped (scoreboard).
// 4. re=16'h8000, im=16'h8000 in lane 3, others 0 -> peak_mag=65534, peak_idx=3.
// 5. Full 1024-bin run at 1 pair per 16 cycles, then done
//    -> out_idx wraps to 0 after 1023; rx_done=1 after the last accept; ovf=0.
// 6. Single real beat, then done -> orphan=1, no output, rx_done=1.
//    Also assert rst=0 mid-drain -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fft_rx_pkg.sv
// Shared widths, sample/frame types and FSM state encodings for the FFT
// frame receiver.
package fft_rx_pkg;
    localparam int W     = 16;
    localparam int LANES = 16;
    localparam int NBINS = 1024;
    localparam int IDXW  = 10;
    localparam int CNTW  = $clog2(LANES);

    typedef logic signed [W-1:0] sample_t;
    typedef sample_t frame_t [LANES];

    typedef enum logic {WAIT_RE, WAIT_IM} pair_st_e;
    typedef enum logic {IDLE, DRAIN} drain_st_e;
endpackage

// File: rtl/fft_abs_sum.sv
// Combinational |re| + |im| on signed Q8.8 samples, with the most negative
// value saturating to the most positive so the sum never exceeds 65534.
module fft_abs_sum
    import fft_rx_pkg::*;
(
    input  logic [W-1:0] re,
    input  logic [W-1:0] im,
    output logic [W:0]   mag
);
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] abs_re;
    logic [W-1:0] abs_im;

    always_comb begin
        abs_re = re;
        abs_im = im;
        if (re[W-1]) abs_re = (re == SMIN) ? SMAX : -re;
        if (im[W-1]) abs_im = (im == SMIN) ? SMAX : -im;
        mag = {1'b0, abs_re} + {1'b0, abs_im};
    end
endmodule

// File: rtl/fft_frame_rx.sv
// Pairs real/imag FFT frames into a two-slot ping-pong buffer and streams one
// complex bin per accepted cycle, tracking the peak-magnitude bin of each frame.
module fft_frame_rx
    import fft_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fft_valid,
    input  logic [W*LANES-1:0]   fft_bus,
    input  logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_re,
    output logic [W-1:0]         out_im,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last,
    output logic                 peak_valid,
    output logic [IDXW-1:0]      peak_idx,
    output logic [W:0]           peak_mag,
    output logic                 ovf,
    output logic                 orphan,
    output logic                 rx_done,
    output logic [1:0]           dbg_st
);
    pair_st_e        pair_st, pair_nx;
    drain_st_e       drain_st, drain_nx;
    frame_t          re_hold;
    frame_t          slot_re [2];
    frame_t          slot_im [2];
    logic [1:0]      full_q, full_nx;
    logic            head, tail;
    logic [CNTW-1:0] cnt;
    logic            done_seen;
    logic [W:0]      mag, cur_max;
    logic [IDXW-1:0] cur_idx;
    logic            beat, accept, last_accept, commit_req, can_commit, commit_ok;

    always_comb begin
        beat        = fft_valid && !done_seen && !rx_done;
        accept      = out_valid && out_ready;
        last_accept = accept && (cnt == CNTW'(LANES-1));
        commit_req  = beat && (pair_st == WAIT_IM);
        // The head slot being released this cycle may be the one the commit targets.
        can_commit  = !full_q[tail] || (last_accept && (head == tail));
        commit_ok   = commit_req && can_commit;
        full_nx     = full_q;
        if (last_accept) full_nx[head] = 1'b0;
        if (commit_ok)   full_nx[tail] = 1'b1;
    end

    always_comb begin
        pair_nx = pair_st;
        case (pair_st)
            WAIT_RE: if (beat) pair_nx = WAIT_IM;
            WAIT_IM: if (beat || done_seen) pair_nx = WAIT_RE;
            default: pair_nx = WAIT_RE;
        endcase
    end

    always_comb begin
        drain_nx = drain_st;
        case (drain_st)
            IDLE:    if (full_nx != 2'b00) drain_nx = DRAIN;
            DRAIN:   if (full_nx == 2'b00) drain_nx = IDLE;
            default: drain_nx = IDLE;
        endcase
    end

    // Stream: a bin transfers on any cycle with out_valid && out_ready; while
    // out_valid is high and out_ready low, out_re/out_im/out_idx/out_last hold.
    always_comb begin
        out_valid = (drain_st == DRAIN);
        out_re    = '0;
        out_im    = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_re   = slot_re[head][cnt];
            out_im   = slot_im[head][cnt];
            out_last = (cnt == CNTW'(LANES-1));
        end
        dbg_st = {drain_st, pair_st};
    end

    fft_abs_sum u_abs (
        .re  (out_re),
        .im  (out_im),
        .mag (mag)
    );

    always_ff @(posedge clk) begin
        if (beat && pair_st == WAIT_RE)
            for (int k = 0; k < LANES; k++) re_hold[k] <= fft_bus[W*k +: W];
        if (commit_ok) begin
            slot_re[tail] <= re_hold;
            for (int k = 0; k < LANES; k++) slot_im[tail][k] <= fft_bus[W*k +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pair_st    <= WAIT_RE;
            drain_st   <= IDLE;
            full_q     <= 2'b00;
            head       <= 1'b0;
            tail       <= 1'b0;
            cnt        <= '0;
            out_idx    <= '0;
            done_seen  <= 1'b0;
            ovf        <= 1'b0;
            orphan     <= 1'b0;
            rx_done    <= 1'b0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            cur_max    <= '0;
            cur_idx    <= '0;
        end else begin
            pair_st    <= pair_nx;
            drain_st   <= drain_nx;
            full_q     <= full_nx;
            done_seen  <= done_seen | done;
            peak_valid <= last_accept;
            if (commit_ok) tail <= ~tail;
            if (commit_req && !can_commit) ovf <= 1'b1;
            if (done_seen && pair_st == WAIT_IM) orphan <= 1'b1;
            if (done_seen && pair_st == WAIT_RE && full_q == 2'b00 && drain_st == IDLE)
                rx_done <= 1'b1;
            if (accept) begin
                out_idx <= (out_idx == IDXW'(NBINS-1)) ? '0 : out_idx + 1'b1;
                cnt     <= last_accept ? '0 : cnt + 1'b1;
                // Strict compare keeps the earliest bin on ties.
                if (cnt == '0 || mag > cur_max) begin
                    cur_max <= mag;
                    cur_idx <= out_idx;
                end
                if (last_accept) begin
                    head     <= ~head;
                    peak_mag <= (mag > cur_max) ? mag : cur_max;
                    peak_idx <= (mag > cur_max) ? out_idx : cur_idx;
                end
            end
        end
    end
endmodule
